exu_md: RTL and testbench
=========================

EXU_MD -- requirements
Module: exu_md

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter REGADDR_W, default 5, register-address width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 valid_i  in  1  execute-stage instruction present.
REQ-006 flush_i  in  1  abort any in-flight operation.
REQ-007 alu_op_i  in  ALUCTL_WIDTH  ALU operation; uses the existing ALUCTL encodings.
REQ-008 md_op_i  in  3  M-extension op: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
REQ-009 md_sel_i  in  1  1 = instruction is M-extension; alu_op_i is ignored.
REQ-010 src1_i, src2_i  in  XLEN  operands.
REQ-011 pc_i, link_addr_i  in  XLEN  instruction address; jal/jalr link value.
REQ-012 reg_we_i / reg_waddr_i  in  1 / REGADDR_W  writeback control.
REQ-013 valid_o  out  1  result_o is valid this cycle.
REQ-014 result_o  out  XLEN  writeback data.
REQ-015 reg_we_o / reg_waddr_o  out  1 / REGADDR_W  writeback control, aligned with result_o.
REQ-016 stallreq_o  out  1  to pipe_ctrl: hold the upstream stage.

Function
REQ-017 ALU ops (ADD…LUI, AUIPC=src2+pc, JAL/JALR=link_addr) are combinational: valid_o=valid_i and result_o is available in the same cycle, with no stall.
REQ-018 Shift amounts use src2_i[log2(XLEN)-1:0].
REQ-019 M-ops use an FSM with states IDLE, CALC and DONE.
REQ-020 IDLE->CALC occurs when valid_i&md_sel_i&!flush_i. At that edge, operands, op, reg_we and reg_waddr are latched and the count is set to XLEN.
REQ-021 CALC advances one quotient/product bit per cycle. CALC->DONE occurs when the count reaches 0.
REQ-022 DONE asserts valid_o for exactly one cycle with the latched reg_we/waddr, then returns to IDLE.
REQ-023 stallreq_o is high from the accept cycle through the last CALC cycle. It is low in DONE.
REQ-024 Total latency from accept to valid_o is XLEN+1 cycles.
REQ-025 While busy, input changes are ignored.
REQ-026 Divide by zero skips CALC and goes IDLE->DONE, with 1-cycle latency. DIV/DIVU return all ones; REM/REMU return the dividend.
REQ-027 Signed overflow (DIV or REM of -2^(XLEN-1) by -1) skips CALC. DIV returns the dividend; REM returns 0.
REQ-028 Signed divide is performed on magnitudes with sign correction: quotient sign = s1^s2, remainder sign = s1.
REQ-029 MULH, MULHSU and MULHU return the upper XLEN bits of a 2·XLEN product. MUL returns the lower XLEN bits.
REQ-030 flush_i in any state forces IDLE at the next edge, suppresses valid_o and drops stallreq_o that cycle. Flush has priority over acceptance.
REQ-031 valid_i in DONE with an M-op starts a new operation only in the following IDLE cycle. No back-to-back accept from DONE.

Reset
REQ-032 rst_n low forces IDLE immediately, including mid-operation.
REQ-033 On reset: state=IDLE, count=0, latched registers=0, valid_o=0, stallreq_o=0, reg_we_o=0.
REQ-034 After reset the block accepts a new op on the first valid cycle.

Configuration
REQ-035 The macro is EXU_FAST_MUL_EN.
REQ-036 With EXU_FAST_MUL_EN defined, the MUL-family ops are single-cycle combinational like the ALU ops. Only DIV/REM use the FSM.
REQ-037 Without EXU_FAST_MUL_EN, MUL-family ops use the iterative shift-add path in the same FSM, with latency XLEN+1.

Structure
REQ-038 The MD_* op encodings, FSM state encodings and XLEN-derived widths belong in a shared package.
REQ-039 The ALUCTL encodings are reused from the existing definitions.
REQ-040 A sub-module mdu_iter holds the FSM, counter and shift/add/subtract datapath. exu_md contains the ALU mux and output selection.

Verification
REQ-041 ADD src1=5, src2=7 -> same-cycle valid_o=1, result=12, stallreq_o=0.
REQ-042 DIV -20/3 (XLEN=32) -> stallreq high 33 cycles, then valid_o with result=-6. REM gives -2.
REQ-043 DIVU x/0 -> valid_o after 1 cycle with 0xFFFFFFFF. REMU 9/0 -> 9.
REQ-044 DIV 0x80000000/-1 -> 0x80000000. REM of the same operands -> 0.
REQ-045 MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MUL -> 0x00000001. Latency is 0 with EXU_FAST_MUL_EN and 33 without.
REQ-046 flush_i at CALC cycle 10, or rst_n low at cycle 10 -> no valid_o, stallreq_o=0. The next DIV 100/7 gives 14.

Source files
------------

// File: rtl/exu_md_pkg.sv
// Shared definitions for the execute-stage ALU / M-extension block.
// Holds ALUCTL encodings, M-op encodings, MDU FSM states and XLEN-derived width helpers.
package exu_md_pkg;

    localparam int ALUCTL_WIDTH = 4;

    typedef enum logic [ALUCTL_WIDTH-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_AUIPC = 4'd11,
        ALU_JAL   = 4'd12,
        ALU_JALR  = 4'd13
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic int shamt_w(input int xlen);
        return $clog2(xlen);
    endfunction

    // Counter must hold the value XLEN itself, hence one extra bit.
    function automatic int cnt_w(input int xlen);
        return $clog2(xlen) + 1;
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/exu_md_mdu_iter.sv
// Iterative multiply/divide unit: IDLE/CALC/DONE FSM, bit counter and a shared
// shift-add (multiply) / restoring shift-subtract (divide) datapath on operand magnitudes.
module mdu_iter
    import exu_md_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REGADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 start_i,
    input  md_op_e               op_i,
    input  logic [XLEN-1:0]      src1_i,
    input  logic [XLEN-1:0]      src2_i,
    input  logic                 reg_we_i,
    input  logic [REGADDR_W-1:0] reg_waddr_i,
    output logic                 busy_o,
    output logic                 stall_o,
    output logic                 done_o,
    output logic [XLEN-1:0]      result_o,
    output logic                 reg_we_o,
    output logic [REGADDR_W-1:0] reg_waddr_o
);

    localparam int CW = cnt_w(XLEN);

    md_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    md_op_e               op_q, op_d;
    logic [XLEN-1:0]      a_q, a_d;
    logic [XLEN-1:0]      b_q, b_d;
    logic [XLEN-1:0]      hi_q, hi_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 we_q, we_d;
    logic [REGADDR_W-1:0] waddr_q, waddr_d;

    logic                 sgn1, sgn2, s1, s2, div_zero, div_ovf;
    logic [XLEN-1:0]      mag1, mag2;
    logic [XLEN:0]        rem_sh, diff, add_sum;
    logic [2*XLEN-1:0]    prod, prod_s;

    always_comb begin
        sgn1     = (op_i == MD_MULH) || (op_i == MD_MULHSU) || (op_i == MD_DIV) || (op_i == MD_REM);
        sgn2     = (op_i == MD_MULH) || (op_i == MD_DIV) || (op_i == MD_REM);
        s1       = sgn1 & src1_i[XLEN-1];
        s2       = sgn2 & src2_i[XLEN-1];
        mag1     = s1 ? -src1_i : src1_i;
        mag2     = s2 ? -src2_i : src2_i;
        div_zero = md_is_div(op_i) && (src2_i == '0);
        div_ovf  = md_is_div(op_i) && sgn2 && (src1_i == {1'b1, {(XLEN-1){1'b0}}}) && (src2_i == '1);
    end

    // hi_q is the product accumulator for multiply and the partial remainder for divide.
    always_comb begin
        rem_sh  = {hi_q, a_q[XLEN-1]};
        diff    = rem_sh - {1'b0, b_q};
        add_sum = {1'b0, hi_q} + (a_q[0] ? {1'b0, b_q} : '0);
    end

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        we_d      = we_q;
        waddr_d   = waddr_q;

        case (state_q)
            MD_IDLE: begin
                if (start_i && !flush_i) begin
                    op_d    = op_i;
                    we_d    = reg_we_i;
                    waddr_d = reg_waddr_i;
                    b_d     = mag2;
                    if (div_zero) begin
                        a_d       = '1;
                        hi_d      = src1_i;
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = MD_DONE;
                    end else if (div_ovf) begin
                        a_d       = src1_i;
                        hi_d      = '0;
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = MD_DONE;
                    end else begin
                        a_d       = mag1;
                        hi_d      = '0;
                        neg_res_d = s1 ^ s2;
                        neg_rem_d = s1;
                        cnt_d     = CW'(XLEN);
                        state_d   = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                if (md_is_div(op_q)) begin
                    if (!diff[XLEN]) begin
                        hi_d = diff[XLEN-1:0];
                        a_d  = {a_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = rem_sh[XLEN-1:0];
                        a_d  = {a_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    hi_d = add_sum[XLEN:1];
                    a_d  = {add_sum[0], a_q[XLEN-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_d == '0) state_d = MD_DONE;
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase

        if (flush_i) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the operand/result registers are
    // reset too so a flushed or reset operation never leaks stale writeback control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            op_q      <= MD_MUL;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
        end
    end

    always_comb begin
        prod   = {hi_q, a_q};
        prod_s = neg_res_q ? -prod : prod;
        case (op_q)
            MD_MUL:                        result_o = prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  result_o = prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               result_o = neg_res_q ? -a_q : a_q;
            default:                       result_o = neg_rem_q ? -hi_q : hi_q;
        endcase
    end

    assign busy_o      = (state_q != MD_IDLE);
    assign stall_o     = !flush_i && (((state_q == MD_IDLE) && start_i) || (state_q == MD_CALC));
    assign done_o      = (state_q == MD_DONE) && !flush_i;
    assign reg_we_o    = we_q;
    assign reg_waddr_o = waddr_q;

endmodule

// File: rtl/exu_md.sv
// Execute stage: combinational ALU plus M-extension via mdu_iter, with output selection.
// Define EXU_FAST_MUL_EN to make MUL/MULH/MULHSU/MULHU single-cycle; only DIV/REM then iterate.
module exu_md
    import exu_md_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REGADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_i,
    input  logic                    flush_i,
    input  logic [ALUCTL_WIDTH-1:0] alu_op_i,
    input  logic [2:0]              md_op_i,
    input  logic                    md_sel_i,
    input  logic [XLEN-1:0]         src1_i,
    input  logic [XLEN-1:0]         src2_i,
    input  logic [XLEN-1:0]         pc_i,
    input  logic [XLEN-1:0]         link_addr_i,
    input  logic                    reg_we_i,
    input  logic [REGADDR_W-1:0]    reg_waddr_i,
    output logic                    valid_o,
    output logic [XLEN-1:0]         result_o,
    output logic                    reg_we_o,
    output logic [REGADDR_W-1:0]    reg_waddr_o,
    output logic                    stallreq_o
);

    localparam int SW = shamt_w(XLEN);

    alu_op_e              alu_op;
    md_op_e               md_op;
    logic [SW-1:0]        shamt;
    logic [XLEN-1:0]      alu_res, comb_res, iter_result;
    logic                 comb_ok, iter_start, iter_busy, iter_stall, iter_done, iter_we;
    logic [REGADDR_W-1:0] iter_waddr;

    assign alu_op = alu_op_e'(alu_op_i);
    assign md_op  = md_op_e'(md_op_i);
    assign shamt  = src2_i[SW-1:0];

    always_comb begin
        case (alu_op)
            ALU_ADD:   alu_res = src1_i + src2_i;
            ALU_SUB:   alu_res = src1_i - src2_i;
            ALU_SLL:   alu_res = src1_i << shamt;
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
            ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, src1_i < src2_i};
            ALU_XOR:   alu_res = src1_i ^ src2_i;
            ALU_SRL:   alu_res = src1_i >> shamt;
            ALU_SRA:   alu_res = $unsigned($signed(src1_i) >>> shamt);
            ALU_OR:    alu_res = src1_i | src2_i;
            ALU_AND:   alu_res = src1_i & src2_i;
            ALU_LUI:   alu_res = src2_i;
            ALU_AUIPC: alu_res = src2_i + pc_i;
            ALU_JAL,
            ALU_JALR:  alu_res = link_addr_i;
            default:   alu_res = '0;
        endcase
    end

`ifdef EXU_FAST_MUL_EN
    logic [2*XLEN-1:0] fm_a, fm_b, fm_prod;
    logic [XLEN-1:0]   fm_res;

    // Sign-extending to 2*XLEN lets one unsigned multiply serve every MUL variant.
    always_comb begin
        fm_a    = {{XLEN{(md_op == MD_MULH || md_op == MD_MULHSU) & src1_i[XLEN-1]}}, src1_i};
        fm_b    = {{XLEN{(md_op == MD_MULH) & src2_i[XLEN-1]}}, src2_i};
        fm_prod = fm_a * fm_b;
        fm_res  = (md_op == MD_MUL) ? fm_prod[XLEN-1:0] : fm_prod[2*XLEN-1:XLEN];
    end

    assign iter_start = valid_i && md_sel_i && md_is_div(md_op) && !flush_i;
    assign comb_ok    = !md_sel_i || !md_is_div(md_op);
    assign comb_res   = md_sel_i ? fm_res : alu_res;
`else
    assign iter_start = valid_i && md_sel_i && !flush_i;
    assign comb_ok    = !md_sel_i;
    assign comb_res   = alu_res;
`endif

    mdu_iter #(
        .XLEN      (XLEN),
        .REGADDR_W (REGADDR_W)
    ) u_mdu_iter (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .start_i     (iter_start),
        .op_i        (md_op),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .reg_we_i    (reg_we_i),
        .reg_waddr_i (reg_waddr_i),
        .busy_o      (iter_busy),
        .stall_o     (iter_stall),
        .done_o      (iter_done),
        .result_o    (iter_result),
        .reg_we_o    (iter_we),
        .reg_waddr_o (iter_waddr)
    );

    // While the MDU is busy the combinational path is masked so held inputs are ignored.
    always_comb begin
        valid_o     = 1'b0;
        result_o    = comb_res;
        reg_we_o    = 1'b0;
        reg_waddr_o = reg_waddr_i;
        if (iter_done) begin
            valid_o     = 1'b1;
            result_o    = iter_result;
            reg_we_o    = iter_we;
            reg_waddr_o = iter_waddr;
        end else if (!iter_busy && comb_ok && valid_i && !flush_i) begin
            valid_o  = 1'b1;
            reg_we_o = reg_we_i;
        end
    end

    assign stallreq_o = iter_stall;

endmodule

// File: tb/tb_exu_md.sv
// Directed scoreboard bench for exu_md (XLEN=32): ALU ops, iterative DIV/REM/MUL,
// divide-by-zero and overflow shortcuts, flush and asynchronous reset mid-operation.
module tb_exu_md;
    import exu_md_pkg::*;

    localparam int XLEN = 32;
`ifdef EXU_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic [4:0]      waddr;
    } sb_item_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              valid_i, flush_i, md_sel_i, reg_we_i;
    logic [3:0]        alu_op_i;
    logic [2:0]        md_op_i;
    logic [XLEN-1:0]   src1_i, src2_i, pc_i, link_addr_i;
    logic [4:0]        reg_waddr_i;
    logic              valid_o, reg_we_o, stallreq_o;
    logic [XLEN-1:0]   result_o;
    logic [4:0]        reg_waddr_o;

    sb_item_t          sb[$];
    int                vectors = 0;
    int                miscompares = 0;
    logic [4:0]        next_waddr = 5'd1;

    exu_md #(.XLEN(XLEN), .REGADDR_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (valid_i),
        .flush_i     (flush_i),
        .alu_op_i    (alu_op_i),
        .md_op_i     (md_op_i),
        .md_sel_i    (md_sel_i),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .pc_i        (pc_i),
        .link_addr_i (link_addr_i),
        .reg_we_i    (reg_we_i),
        .reg_waddr_i (reg_waddr_i),
        .valid_o     (valid_o),
        .result_o    (result_o),
        .reg_we_o    (reg_we_o),
        .reg_waddr_o (reg_waddr_o),
        .stallreq_o  (stallreq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_i  = 1'b0;
        flush_i  = 1'b0;
        md_sel_i = 1'b0;
        reg_we_i = 1'b0;
    endtask

    // Drive one instruction, wait for valid_o, compare against the scoreboard, latency and stall count.
    task automatic do_op(input string tag, input logic md, input alu_op_e aop, input md_op_e mop,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] pc, input logic [XLEN-1:0] link,
                         input logic [XLEN-1:0] exp, input int exp_lat);
        int       lat = 0;
        int       stalls = 0;
        logic     got = 1'b0;
        sb_item_t item;
        @(posedge clk); #1;
        valid_i = 1'b1; md_sel_i = md; alu_op_i = aop; md_op_i = mop;
        src1_i = a; src2_i = b; pc_i = pc; link_addr_i = link;
        reg_we_i = 1'b1; reg_waddr_i = next_waddr;
        sb.push_back('{res: exp, waddr: next_waddr});
        next_waddr++;
        while (!got && lat < 200) begin
            @(negedge clk);
            if (stallreq_o) stalls++;
            if (valid_o) begin
                got = 1'b1;
                if (sb.size() == 0) begin
                    check({tag, "_sb_underflow"}, 64'(sb.size()), 64'd1);
                end else begin
                    item = sb.pop_front();
                    check({tag, "_result"}, 64'(result_o), 64'(item.res));
                    check({tag, "_waddr"}, 64'(reg_waddr_o), 64'(item.waddr));
                    check({tag, "_we"}, 64'(reg_we_o), 64'd1);
                end
            end else begin
                @(posedge clk); #1;
                valid_i = 1'b0;
                lat++;
            end
        end
        check({tag, "_timeout"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_lat));
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Start a DIV, let it run 10 cycles, then abort it with flush or reset.
    task automatic abort_div(input string tag, input logic use_reset);
        logic seen = 1'b0;
        @(posedge clk); #1;
        valid_i = 1'b1; md_sel_i = 1'b1; md_op_i = MD_DIV;
        src1_i = 32'd1000; src2_i = 32'd3; reg_we_i = 1'b1; reg_waddr_i = 5'd30;
        @(posedge clk); #1;
        idle_inputs();
        repeat (9) @(posedge clk);
        #1;
        if (use_reset) begin
            rst_n = 1'b0;
            #1;
            check({tag, "_now"}, {61'd0, stallreq_o, valid_o, reg_we_o}, 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            flush_i = 1'b1;
            @(negedge clk);
            check({tag, "_now"}, {62'd0, stallreq_o, valid_o}, 64'd0);
            @(posedge clk); #1;
            flush_i = 1'b0;
        end
        repeat (40) begin
            @(negedge clk);
            if (valid_o || stallreq_o) seen = 1'b1;
        end
        check({tag, "_quiet"}, 64'(seen), 64'd0);
    endtask

    initial begin
        idle_inputs();
        alu_op_i = 4'd0; md_op_i = 3'd0;
        src1_i = '0; src2_i = '0; pc_i = '0; link_addr_i = '0; reg_waddr_i = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {61'd0, valid_o, stallreq_o, reg_we_o}, 64'd0);
        rst_n = 1'b1;

        do_op("add",    1'b0, ALU_ADD,   MD_MUL, 32'd5,        32'd7,        '0,         '0,       32'd12,       0);
        do_op("sub",    1'b0, ALU_SUB,   MD_MUL, 32'd5,        32'd7,        '0,         '0,       32'hFFFFFFFE, 0);
        do_op("sra",    1'b0, ALU_SRA,   MD_MUL, 32'h80000000, 32'h24,       '0,         '0,       32'hF8000000, 0);
        do_op("sltu",   1'b0, ALU_SLTU,  MD_MUL, 32'd1,        32'hFFFFFFFF, '0,         '0,       32'd1,        0);
        do_op("auipc",  1'b0, ALU_AUIPC, MD_MUL, '0,           32'h1000,     32'h200,    '0,       32'h1200,     0);
        do_op("jal",    1'b0, ALU_JAL,   MD_MUL, 32'd9,        32'd9,        32'h40,     32'h44,   32'h44,       0);

        do_op("div",    1'b1, ALU_ADD, MD_DIV,    -32'sd20,     32'd3,        '0, '0, 32'hFFFFFFFA, XLEN + 1);
        do_op("rem",    1'b1, ALU_ADD, MD_REM,    -32'sd20,     32'd3,        '0, '0, 32'hFFFFFFFE, XLEN + 1);
        do_op("divu_z", 1'b1, ALU_ADD, MD_DIVU,   32'd5,        32'd0,        '0, '0, 32'hFFFFFFFF, 1);
        do_op("remu_z", 1'b1, ALU_ADD, MD_REMU,   32'd9,        32'd0,        '0, '0, 32'd9,        1);
        do_op("div_ov", 1'b1, ALU_ADD, MD_DIV,    32'h80000000, 32'hFFFFFFFF, '0, '0, 32'h80000000, 1);
        do_op("rem_ov", 1'b1, ALU_ADD, MD_REM,    32'h80000000, 32'hFFFFFFFF, '0, '0, 32'd0,        1);
        do_op("mulhu",  1'b1, ALU_ADD, MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, '0, '0, 32'hFFFFFFFE, MUL_LAT);
        do_op("mul",    1'b1, ALU_ADD, MD_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, '0, '0, 32'h00000001, MUL_LAT);
        do_op("mulh",   1'b1, ALU_ADD, MD_MULH,   -32'sd3,      32'd5,        '0, '0, 32'hFFFFFFFF, MUL_LAT);
        do_op("mulhsu", 1'b1, ALU_ADD, MD_MULHSU, 32'hFFFFFFFF, 32'd2,        '0, '0, 32'hFFFFFFFF, MUL_LAT);
        do_op("divu",   1'b1, ALU_ADD, MD_DIVU,   32'd100,      32'd7,        '0, '0, 32'd14,       XLEN + 1);

        abort_div("flush", 1'b0);
        do_op("div_after_flush", 1'b1, ALU_ADD, MD_DIV, 32'd100, 32'd7, '0, '0, 32'd14, XLEN + 1);
        abort_div("reset", 1'b1);
        do_op("div_after_reset", 1'b1, ALU_ADD, MD_DIV, 32'd100, 32'd7, '0, '0, 32'd14, XLEN + 1);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
